// File: rtl/ifu_fetch_pkg.sv
// Shared core constants and fetch-stage types for the instruction fetch unit.
// RESET_PC must track the PC unit reset value.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH = 64;
    localparam int MEM_DATA_W = 64;
    localparam int INST_W = 32;
    localparam logic [CPU_WIDTH-1:0] RESET_PC = 64'h8000_0000;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_DROP = 3'd3,
        FS_OUT  = 3'd4
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_wsel.sv
// Picks the 32-bit instruction word out of an aligned 64-bit read, using pc[2].
module ifu_wsel
    import ifu_fetch_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int WORD_W = INST_W
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic              sel_hi,
    output logic [WORD_W-1:0] word
);

    assign word = sel_hi ? rdata[2*WORD_W-1:WORD_W] : rdata[WORD_W-1:0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one PC in, one aligned memory read, one instruction out.
// Handshakes: a transfer happens on a cycle where valid and ready are both high.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int                ADDR_W   = CPU_WIDTH,
    parameter int                DATA_W   = MEM_DATA_W,
    parameter int                INST_W   = ifu_fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ifu_fetch_pkg::RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_pc_vld,
    output logic              o_pc_rdy,
    input  logic              i_flush,
    output logic              o_mem_req_vld,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_req_rdy,
    input  logic              i_mem_rsp_vld,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_rsp_rdy,
    output logic              o_inst_vld,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_misal,
    input  logic              i_inst_rdy,
    output logic [2:0]        o_fsm_state
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] sel_word;

    ifu_wsel #(
        .DATA_W (DATA_W),
        .WORD_W (INST_W)
    ) u_wsel (
        .rdata  (i_mem_rdata),
        .sel_hi (pc_q[2]),
        .word   (sel_word)
    );

    // Flush is tested first in every state so it always wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            o_inst       <= '0;
            o_inst_pc    <= RESET_PC;
            o_inst_misal <= 1'b0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (i_pc_vld && !i_flush) begin
                        pc_q <= i_pc;
                        if (is_misaligned(i_pc[1:0])) begin
                            o_inst       <= '0;
                            o_inst_pc    <= i_pc;
                            o_inst_misal <= 1'b1;
                            state_q      <= FS_OUT;
                        end else begin
                            state_q <= FS_REQ;
                        end
                    end
                end
                FS_REQ: begin
                    if (i_flush) begin
                        // An already-accepted request still owes us a response.
                        state_q <= i_mem_req_rdy ? FS_DROP : FS_IDLE;
                    end else if (i_mem_req_rdy) begin
                        state_q <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (i_flush) begin
                        state_q <= i_mem_rsp_vld ? FS_IDLE : FS_DROP;
                    end else if (i_mem_rsp_vld) begin
                        o_inst       <= sel_word;
                        o_inst_pc    <= pc_q;
                        o_inst_misal <= 1'b0;
                        state_q      <= FS_OUT;
                    end
                end
                FS_DROP: begin
                    if (i_mem_rsp_vld) begin
                        state_q <= FS_IDLE;
                    end
                end
                FS_OUT: begin
                    if (i_flush || i_inst_rdy) begin
                        state_q <= FS_IDLE;
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    assign o_pc_rdy      = (state_q == FS_IDLE);
    assign o_mem_req_vld = (state_q == FS_REQ);
    assign o_mem_rsp_rdy = (state_q == FS_WAIT) || (state_q == FS_DROP);
    assign o_inst_vld    = (state_q == FS_OUT);
    assign o_mem_addr    = {pc_q[ADDR_W-1:3], 3'b000};
    assign o_fsm_state   = state_q;

    a_req_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_mem_req_vld && !i_mem_req_rdy && !i_flush) |=> (o_mem_req_vld && $stable(o_mem_addr)));

    a_out_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_inst_vld && !i_inst_rdy && !i_flush) |=>
            (o_inst_vld && $stable(o_inst) && $stable(o_inst_pc) && $stable(o_inst_misal)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: basic and upper-word fetch, backpressure, flushes,
// misaligned PC and asynchronous reset during a request.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [63:0] i_pc;
    logic        i_pc_vld;
    logic        o_pc_rdy;
    logic        i_flush;
    logic        o_mem_req_vld;
    logic [63:0] o_mem_addr;
    logic        i_mem_req_rdy;
    logic        i_mem_rsp_vld;
    logic [63:0] i_mem_rdata;
    logic        o_mem_rsp_rdy;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic        o_inst_misal;
    logic        i_inst_rdy;
    logic [2:0]  o_fsm_state;

    int n_checks = 0;
    int n_fails  = 0;
    logic saw_deadbeef = 1'b0;

    ifu_fetch dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pc          (i_pc),
        .i_pc_vld      (i_pc_vld),
        .o_pc_rdy      (o_pc_rdy),
        .i_flush       (i_flush),
        .o_mem_req_vld (o_mem_req_vld),
        .o_mem_addr    (o_mem_addr),
        .i_mem_req_rdy (i_mem_req_rdy),
        .i_mem_rsp_vld (i_mem_rsp_vld),
        .i_mem_rdata   (i_mem_rdata),
        .o_mem_rsp_rdy (o_mem_rsp_rdy),
        .o_inst_vld    (o_inst_vld),
        .o_inst        (o_inst),
        .o_inst_pc     (o_inst_pc),
        .o_inst_misal  (o_inst_misal),
        .i_inst_rdy    (i_inst_rdy),
        .o_fsm_state   (o_fsm_state)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_inst_vld && o_inst == 32'hDEAD_BEEF) saw_deadbeef <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_fetch(input logic [63:0] pc, input logic [63:0] exp_addr,
                            input logic [63:0] rdata, input logic [31:0] exp_inst);
        i_pc = pc; i_pc_vld = 1'b1; i_mem_req_rdy = 1'b1; i_inst_rdy = 1'b1;
        check("idle_pc_rdy", o_pc_rdy, 1);
        step();
        i_pc_vld = 1'b0;
        check("req_vld", o_mem_req_vld, 1);
        check("req_addr", o_mem_addr, exp_addr);
        check("req_pc_rdy", o_pc_rdy, 0);
        step();
        check("wait_rsp_rdy", o_mem_rsp_rdy, 1);
        check("wait_req_vld", o_mem_req_vld, 0);
        i_mem_rsp_vld = 1'b1; i_mem_rdata = rdata;
        step();
        i_mem_rsp_vld = 1'b0;
        check("out_vld", o_inst_vld, 1);
        check("out_inst", o_inst, exp_inst);
        check("out_pc", o_inst_pc, pc);
        check("out_misal", o_inst_misal, 0);
        step();
        check("back_idle_vld", o_inst_vld, 0);
        check("back_idle_pc_rdy", o_pc_rdy, 1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_pc = '0; i_pc_vld = 1'b0; i_flush = 1'b0;
        i_mem_req_rdy = 1'b0; i_mem_rsp_vld = 1'b0; i_mem_rdata = '0; i_inst_rdy = 1'b0;
        #12;
        check("rst_pc_rdy", o_pc_rdy, 1);
        check("rst_req_vld", o_mem_req_vld, 0);
        check("rst_rsp_rdy", o_mem_rsp_rdy, 0);
        check("rst_inst_vld", o_inst_vld, 0);
        check("rst_inst", o_inst, 0);
        check("rst_inst_pc", o_inst_pc, 64'h8000_0000);
        check("rst_misal", o_inst_misal, 0);
        check("rst_state", o_fsm_state, 3'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();

        // Basic fetch, then upper-word select from the same doubleword
        do_fetch(64'h8000_0000, 64'h8000_0000, 64'h0000_0013_0010_0093, 32'h0010_0093);
        do_fetch(64'h8000_0004, 64'h8000_0000, 64'h0000_0013_0010_0093, 32'h0000_0013);

        // Backpressure on both the request and the output side
        i_pc = 64'h8000_0008; i_pc_vld = 1'b1; i_mem_req_rdy = 1'b0; i_inst_rdy = 1'b0;
        step();
        i_pc_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_req_vld", o_mem_req_vld, 1);
            check("bp_req_addr", o_mem_addr, 64'h8000_0008);
            check("bp_req_pc_rdy", o_pc_rdy, 0);
            step();
        end
        check("bp_req_vld_last", o_mem_req_vld, 1);
        i_mem_req_rdy = 1'b1;
        step();
        i_mem_rsp_vld = 1'b1; i_mem_rdata = 64'h1111_1111_2222_2222;
        step();
        i_mem_rsp_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("bp_out_vld", o_inst_vld, 1);
            check("bp_out_inst", o_inst, 32'h2222_2222);
            check("bp_out_pc", o_inst_pc, 64'h8000_0008);
            check("bp_out_pc_rdy", o_pc_rdy, 0);
            step();
        end
        i_inst_rdy = 1'b1;
        step();
        check("bp_done_pc_rdy", o_pc_rdy, 1);

        // Flush in WAIT before the response: the late response must be swallowed
        i_pc = 64'h8000_000C; i_pc_vld = 1'b1; i_mem_req_rdy = 1'b1;
        step();
        i_pc_vld = 1'b0;
        step();
        check("fw_in_wait", o_mem_rsp_rdy, 1);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fw_drop_state", o_fsm_state, 3'd3);
        check("fw_drop_pc_rdy", o_pc_rdy, 0);
        step();
        check("fw_drop_hold", o_mem_rsp_rdy, 1);
        i_mem_rsp_vld = 1'b1; i_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        i_mem_rsp_vld = 1'b0;
        check("fw_dropped_vld", o_inst_vld, 0);
        check("fw_dropped_pc_rdy", o_pc_rdy, 1);
        do_fetch(64'h8000_0010, 64'h8000_0010, 64'h0000_0000_00A0_0513, 32'h00A0_0513);

        // Flush in REQ: withdrawn when not accepted, dropped when accepted
        i_pc = 64'h8000_0018; i_pc_vld = 1'b1; i_mem_req_rdy = 1'b0;
        step();
        i_pc_vld = 1'b0; i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fr_withdraw_req", o_mem_req_vld, 0);
        check("fr_withdraw_pc_rdy", o_pc_rdy, 1);
        i_pc_vld = 1'b1; i_mem_req_rdy = 1'b1;
        step();
        i_pc_vld = 1'b0; i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("fr_accepted_drop", o_fsm_state, 3'd3);
        i_mem_rsp_vld = 1'b1; i_mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        i_mem_rsp_vld = 1'b0;
        check("fr_drop_done", o_pc_rdy, 1);

        // Flush in IDLE blocks the PC transfer; flush in OUT retires the instruction
        i_pc = 64'h8000_0020; i_pc_vld = 1'b1; i_flush = 1'b1;
        step();
        check("fi_no_req", o_mem_req_vld, 0);
        check("fi_pc_rdy", o_pc_rdy, 1);
        i_flush = 1'b0; i_inst_rdy = 1'b0;
        step();
        i_pc_vld = 1'b0;
        step();
        i_mem_rsp_vld = 1'b1; i_mem_rdata = 64'h0000_0000_0000_0073;
        step();
        i_mem_rsp_vld = 1'b0;
        check("fo_out_inst", o_inst, 32'h0000_0073);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_inst_rdy = 1'b1;
        check("fo_out_gone", o_inst_vld, 0);
        check("fo_pc_rdy", o_pc_rdy, 1);

        // Misaligned PC short-circuits the memory access
        i_pc = 64'h8000_0002; i_pc_vld = 1'b1;
        step();
        i_pc_vld = 1'b0;
        check("mis_no_req", o_mem_req_vld, 0);
        check("mis_vld", o_inst_vld, 1);
        check("mis_flag", o_inst_misal, 1);
        check("mis_inst", o_inst, 0);
        check("mis_pc", o_inst_pc, 64'h8000_0002);
        step();
        check("mis_back_idle", o_pc_rdy, 1);

        // Asynchronous reset while a request is pending
        i_pc = 64'h8000_0028; i_pc_vld = 1'b1; i_mem_req_rdy = 1'b0;
        step();
        i_pc_vld = 1'b0;
        check("ar_in_req", o_mem_req_vld, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("ar_req_dropped", o_mem_req_vld, 0);
        check("ar_inst_pc", o_inst_pc, 64'h8000_0000);
        check("ar_misal", o_inst_misal, 0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        step();
        check("ar_pc_rdy", o_pc_rdy, 1);
        check("ar_state", o_fsm_state, 3'd0);

        check("no_deadbeef_out", saw_deadbeef, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
